// File: rtl/key_event_pkg.sv
// Shared types and helpers for the push-button key event path.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_DOWN,
    HELD,
    LONG_HELD,
    DEB_UP
  } key_state_e;

  // Counter width large enough to hold the largest terminal count (max - 1).
  function automatic int unsigned cnt_width(input int unsigned deb_cyc,
                                            input int unsigned long_cyc,
                                            input int unsigned rep_cyc);
    int unsigned m;
    m = deb_cyc;
    if (long_cyc > m) m = long_cyc;
    if (rep_cyc > m) m = rep_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key: 2-flop synchronizer, debounce FSM, hold timer and registered strobes.
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int unsigned DEB_CYC   = 1000000,
  parameter int unsigned LONG_CYC  = 50000000,
  parameter int unsigned REP_CYC   = 10000000,
  parameter int unsigned REPEAT_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(DEB_CYC, LONG_CYC, REP_CYC);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  logic          sw_m;
  logic          sw_s;
  logic          raw_p;
  key_state_e    state;
  logic [CW-1:0] cnt;
  logic          long_flag;

  // Bring the asynchronous switch level into the clock domain; idle is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= 1'b1;
      sw_s <= 1'b1;
    end else begin
      sw_m <= sw_n;
      sw_s <= sw_m;
    end
  end

  assign raw_p = ~sw_s;

  // Debounce / hold / repeat FSM with registered level and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      long_flag     <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (raw_p) begin
            state <= DEB_DOWN;
            cnt   <= '0;
          end
        end
        DEB_DOWN: begin
          if (!raw_p) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!raw_p) begin
            state <= DEB_UP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HELD;
            cnt        <= '0;
            long_pulse <= 1'b1;
            long_flag  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (!raw_p) begin
            state <= DEB_UP;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt          <= '0;
            repeat_pulse <= REP_ON;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB_UP: begin
          // A bounce returns to the hold state with the hold/repeat timer restarted.
          if (raw_p) begin
            state <= long_flag ? LONG_HELD : HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
            long_flag     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Push-button front end: NKEY independent debounced key event channels.
module key_event_gen #(
  parameter int unsigned NKEY      = 3,
  parameter int unsigned DEB_CYC   = 1000000,
  parameter int unsigned LONG_CYC  = 50000000,
  parameter int unsigned REP_CYC   = 10000000,
  parameter int unsigned REPEAT_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] sw_n,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] press_pulse,
  output logic [NKEY-1:0] release_pulse,
  output logic [NKEY-1:0] long_pulse,
  output logic [NKEY-1:0] repeat_pulse
);

  // One fully independent channel per key.
  for (genvar i = 0; i < NKEY; i++) begin : g_chan
    key_event_chan #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC),
      .REP_CYC  (REP_CYC),
      .REPEAT_EN(REPEAT_EN)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .sw_n         (sw_n[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random switch activity
// checked every cycle against a run-length model of the key behaviour.
module tb_key_event_gen;

  localparam int NKEY     = 3;
  localparam int DEB_CYC  = 4;
  localparam int LONG_CYC = 20;
  localparam int REP_CYC  = 8;

  logic            clk;
  logic            rst_n;
  logic [NKEY-1:0] sw_n;

  logic [NKEY-1:0] a_level, a_press, a_rel, a_long, a_rep;
  logic [NKEY-1:0] b_level, b_press, b_rel, b_long, b_rep;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  key_event_gen #(
    .NKEY(NKEY), .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_n(sw_n),
    .key_level(a_level), .press_pulse(a_press), .release_pulse(a_rel),
    .long_pulse(a_long), .repeat_pulse(a_rep)
  );

  key_event_gen #(
    .NKEY(NKEY), .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_n(sw_n),
    .key_level(b_level), .press_pulse(b_press), .release_pulse(b_rel),
    .long_pulse(b_long), .repeat_pulse(b_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NKEY-1:0] act, input logic [NKEY-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is accepted after DEB_CYC+1 consecutive pressed samples,
  // a release after DEB_CYC+1 consecutive released samples; while held, the hold timer
  // counts pressed samples since the press (or since the last bounce back to pressed).
  logic [NKEY-1:0] m_s1, m_s2;
  logic [NKEY-1:0] e_level, e_press, e_rel, e_long, e_rep;
  int ones_run[NKEY];
  int zeros_run[NKEY];
  int hold_t[NKEY];
  bit m_long[NKEY];
  bit prev_raw[NKEY];

  always @(posedge clk or negedge rst_n) begin : model
    bit raw;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1;
      e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      for (int k = 0; k < NKEY; k++) begin
        ones_run[k] = 0; zeros_run[k] = 0; hold_t[k] = 0; m_long[k] = 0; prev_raw[k] = 0;
      end
    end else begin
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      for (int k = 0; k < NKEY; k++) begin
        raw = !m_s2[k];
        if (raw) begin ones_run[k]++; zeros_run[k] = 0; end
        else begin zeros_run[k]++; ones_run[k] = 0; end
        if (!e_level[k]) begin
          if (ones_run[k] == DEB_CYC + 1) begin
            e_level[k] = 1'b1; e_press[k] = 1'b1; hold_t[k] = 0;
          end
        end else if (!raw) begin
          if (zeros_run[k] == DEB_CYC + 1) begin
            e_level[k] = 1'b0; e_rel[k] = 1'b1; m_long[k] = 0;
          end
        end else if (!prev_raw[k]) begin
          hold_t[k] = 0;
        end else begin
          hold_t[k]++;
          if (!m_long[k] && hold_t[k] == LONG_CYC) begin
            m_long[k] = 1; e_long[k] = 1'b1; hold_t[k] = 0;
          end else if (m_long[k] && hold_t[k] == REP_CYC) begin
            e_rep[k] = 1'b1; hold_t[k] = 0;
          end
        end
        prev_raw[k] = raw;
      end
      m_s2 = m_s1;
      m_s1 = sw_n;
    end
  end

  // Per-cycle comparison of both DUTs against the model, well away from the clock edge.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("cmp_level_a",   a_level, e_level);
      chk("cmp_press_a",   a_press, e_press);
      chk("cmp_release_a", a_rel,   e_rel);
      chk("cmp_long_a",    a_long,  e_long);
      chk("cmp_repeat_a",  a_rep,   e_rep);
      chk("cmp_level_b",   b_level, e_level);
      chk("cmp_press_b",   b_press, e_press);
      chk("cmp_release_b", b_rel,   e_rel);
      chk("cmp_long_b",    b_long,  e_long);
      chk("cmp_repeat_b",  b_rep,   '0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_len();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3) return int'($urandom_range(1, 5));
    else if (r < 7) return int'($urandom_range(6, 30));
    else return int'($urandom_range(31, 90));
  endfunction

  int rem[NKEY];

  initial begin
    sw_n  = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level",   a_level, '0);
    chk("reset_press",   a_press, '0);
    chk("reset_release", a_rel,   '0);
    chk("reset_long",    a_long,  '0);
    chk("reset_repeat",  a_rep,   '0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1;
    idle(10);

    // Clean press on key 0: strobe after edge 7, level high from the same edge.
    @(negedge clk);
    sw_n[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      edge_sample();
      chk("clean_press",  a_press, (e == 7) ? 3'b001 : 3'b000);
      chk("clean_level",  a_level, (e >= 7) ? 3'b001 : 3'b000);
      if (e == 7) chk("model_press_e7", e_press, 3'b001);
    end
    idle(2);

    // Bounce on release of key 0: high 2, low 3, then high for good.
    sw_n[0] = 1'b1;
    idle(2);
    sw_n[0] = 1'b0;
    idle(3);
    for (int e = 1; e <= 4; e++) begin
      edge_sample();
      chk("bounce_quiet_rel", a_rel,   3'b000);
      chk("bounce_level",     a_level, 3'b001);
    end
    @(negedge clk);
    sw_n[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      edge_sample();
      chk("bounce_release", a_rel,   (e == 7) ? 3'b001 : 3'b000);
      chk("release_level",  a_level, (e >= 7) ? 3'b000 : 3'b001);
      if (e == 7) chk("model_release_e7", e_rel, 3'b001);
    end
    idle(4);

    // Glitch on key 1: low for 3 cycles is rejected.
    sw_n[1] = 1'b0;
    idle(3);
    sw_n[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      chk("glitch_press", a_press, 3'b000);
      chk("glitch_level", a_level, 3'b000);
    end
    idle(4);

    // Long press with repeat on key 2.
    sw_n[2] = 1'b0;
    for (int e = 1; e <= 62; e++) begin
      edge_sample();
      chk("long_press",  a_press, (e == 7) ? 3'b100 : 3'b000);
      chk("long_long",   a_long,  (e == 27) ? 3'b100 : 3'b000);
      chk("long_rep_a",  a_rep,   (e == 35 || e == 43 || e == 51 || e == 59) ? 3'b100 : 3'b000);
      chk("long_rep_b",  b_rep,   3'b000);
      if (e == 27) chk("model_long_e27", e_long, 3'b100);
      if (e == 35) chk("model_rep_e35",  e_rep,  3'b100);
    end
    @(negedge clk);
    sw_n[2] = 1'b1;
    idle(15);

    // All keys together, then reset while held, then a fresh press with keys still down.
    sw_n = '0;
    for (int e = 1; e <= 7; e++) begin
      edge_sample();
      chk("simul_press", a_press, (e == 7) ? 3'b111 : 3'b000);
    end
    chk("simul_level", a_level, 3'b111);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_level",   a_level, '0);
    chk("rst_mid_press",   a_press, '0);
    chk("rst_mid_release", a_rel,   '0);
    idle(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      chk("post_rst_press",   a_press, (e == 7) ? 3'b111 : 3'b000);
      chk("post_rst_release", a_rel,   3'b000);
      chk("post_rst_level",   a_level, (e >= 7) ? 3'b111 : 3'b000);
    end
    @(negedge clk);
    sw_n = '1;
    idle(15);

    // Random activity on all keys, with one reset in the middle.
    for (int k = 0; k < NKEY; k++) rem[k] = pick_len();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      for (int k = 0; k < NKEY; k++) begin
        if (rem[k] == 0) begin
          sw_n[k] = ~sw_n[k];
          rem[k]  = pick_len();
        end else begin
          rem[k]--;
        end
      end
    end
    @(negedge clk);
    sw_n = '1;
    idle(20);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Producer side of the push-button control path: turns raw active-low switch inputs into clean, one-cycle key event strobes.
- Downstream blocks (marquee LED control, mode select) consume these strobes directly and do no filtering of their own.
- Per key: 2-flop synchronizer, counter-based debounce, press/release strobes, long-press detection and auto-repeat.
- Sits between board switch pins and all key-driven control logic; single 50 MHz clock domain.

Parameters:
- NKEY, 3, number of independent keys.
- DEB_CYC, 1000000, stable-level cycles required to accept a press or a release (20 ms at 50 MHz); legal range ≥2.
- LONG_CYC, 50000000, debounced-hold cycles before long_pulse (1 s); must be > DEB_CYC.
- REP_CYC, 10000000, cycles between repeat_pulse strobes once long-held (200 ms); legal range ≥2.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means no repeat_pulse ever.

Ports:
- clk  input  1  main clock, 50 MHz.
- rst_n  input  1  reset; asynchronous assert, active-low; one clock domain.
- sw_n  input  NKEY  raw switch levels, 0 = pressed; asynchronous to clk.
- key_level  output  NKEY  debounced state, 1 = held.
- press_pulse  output  NKEY  one-cycle strobe on accepted press.
- release_pulse  output  NKEY  one-cycle strobe on accepted release.
- long_pulse  output  NKEY  one-cycle strobe when hold reaches LONG_CYC.
- repeat_pulse  output  NKEY  one-cycle strobe every REP_CYC while long-held.

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops go to 1 (released). FSM goes to IDLE. Counters and the long flag go to 0.
  - All outputs are 0.
  - Reset mid-press gives no release_pulse, both during and after reset.
- Synchronizer: raw_p[i] = ~sw_s[i], where sw_s is the 2nd sync flop. All FSM decisions use raw_p only.
- Each key has an independent FSM. The counter cnt clears on every state change.
  - IDLE: raw_p=1 → DEB_DOWN.
  - DEB_DOWN:
    - raw_p=0 → IDLE (glitch rejected, no strobe).
    - Otherwise cnt++. At cnt==DEB_CYC-1 → HELD; press_pulse=1 for one cycle; key_level=1 in the same cycle.
  - HELD:
    - raw_p=0 → DEB_UP.
    - Otherwise cnt++. At cnt==LONG_CYC-1 → LONG_HELD; long_pulse=1 for one cycle; long flag=1.
  - LONG_HELD:
    - raw_p=0 → DEB_UP.
    - Otherwise cnt++. At cnt==REP_CYC-1: repeat_pulse=1 if REP_EN, cnt=0, stay in LONG_HELD.
  - DEB_UP:
    - raw_p=1 (bounce) → back to HELD or LONG_HELD according to the long flag. The hold/repeat timer restarts from 0; no strobe.
    - Otherwise cnt++. At cnt==DEB_CYC-1 → IDLE; release_pulse=1 for one cycle; key_level=0 in the same cycle; long flag=0.
- All outputs are registered, with no combinational path from sw_n.
- Latency: sw_n falling (set up before edge 1) → press_pulse and key_level high after edge DEB_CYC+3. Release is symmetric.
- Counter width is $clog2(max(DEB_CYC, LONG_CYC, REP_CYC)). The counter never wraps because every terminal count is compared exactly.
- Keys are fully independent. Simultaneous presses on several keys produce strobes in the same cycle on each bit.
- At most one strobe type can be asserted per key per cycle; this is guaranteed by FSM exclusivity.

Decomposition:
- Package key_event_pkg holds:
  - the state enum (IDLE, DEB_DOWN, HELD, LONG_HELD, DEB_UP);
  - the function computing the counter width.
- Sub-module key_event_chan: one key's synchronizer, FSM, counter and registered strobes.
- The top generates NKEY instances.

Test Plan:
(Bench parameters: DEB_CYC=4, LONG_CYC=20, REP_CYC=8, NKEY=3.)
- Clean press: sw_n[0] 1→0 held 10 cycles → press_pulse[0] single cycle after edge 7, key_level[0]=1 from the same edge; other bits remain 0.
- Glitch rejection: sw_n[1] low for 3 cycles, then high → no strobes, key_level[1] stays 0.
- Bounce on release: sw_n[0] goes high for 2 cycles, then low, then high for 6 cycles → no strobe on the first bounce; release_pulse[0] once, 7 edges after the final rise; key_level[0]=0.
- Long press with repeat: sw_n[2] held 60 cycles → press_pulse at edge 7, long_pulse at edge 27, repeat_pulse at edges 35, 43, 51, 59; with REPEAT_EN=0, no repeats.
- Simultaneous keys plus reset mid-hold: all sw_n low together → three press_pulse bits in the same cycle; then rst_n=0 during HELD → outputs 0 immediately; after reset release with keys still low, a fresh press_pulse at edge DEB_CYC+3 and no release_pulse.
